// File: rtl/pwm_pkg.sv
// Shared types and default parameters for the multichannel PWM block.
// Imported by the prescaler and the PWM core.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_t;

    localparam int PWM_DEFAULT_N        = 10;
    localparam int PWM_DEFAULT_CLK_DIV  = 3;
    localparam int PWM_DEFAULT_CHANNELS = 2;

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running prescaler: a one-clk tick every 2^CLK_DIV clocks.
// The tick is a clock enable, never a derived clock.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = PWM_DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [CLK_DIV-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + CLK_DIV'(1);
        end
    end

    // All-ones is the last count before the natural wrap to zero.
    assign tick = &count;

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM with a shared period counter, edge- or center-aligned,
// and shadow registers that only take new settings at the start of a period.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int N        = PWM_DEFAULT_N,
    parameter int CLK_DIV  = PWM_DEFAULT_CLK_DIV,
    parameter int CHANNELS = PWM_DEFAULT_CHANNELS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CHANNELS-1:0][N-1:0] duty,
    input  logic [CHANNELS-1:0]        enable,
    input  logic                       center_mode,
    output logic [CHANNELS-1:0]        pwm_out,
    output logic                       period_start
);

    localparam logic [N-1:0] CNT_MAX = '1;

    logic                       tick;
    logic                       load;
    logic [N-1:0]               counter;
    logic [N-1:0]               counter_next;
    pwm_dir_t                   dir;
    pwm_dir_t                   dir_eff;
    pwm_dir_t                   dir_next;
    pwm_mode_t                  mode;
    pwm_mode_t                  mode_eff;
    logic [CHANNELS-1:0][N-1:0] shadow_duty;
    logic [CHANNELS-1:0][N-1:0] duty_eff;
    logic [CHANNELS-1:0]        shadow_enable;
    logic [CHANNELS-1:0]        enable_eff;
    logic [CHANNELS-1:0]        pwm_next;

    pwm_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // On a load tick the freshly latched settings must already drive this tick's decisions.
    always_comb begin
        load       = tick && (counter == '0);
        mode_eff   = load ? pwm_mode_t'(center_mode) : mode;
        duty_eff   = load ? duty : shadow_duty;
        enable_eff = load ? enable : shadow_enable;
        dir_eff    = load ? DIR_UP : dir;
    end

    always_comb begin
        counter_next = counter + N'(1);
        dir_next     = DIR_UP;
        if (mode_eff == PWM_CENTER) begin
            if (dir_eff == DIR_DOWN || counter == CNT_MAX) begin
                counter_next = counter - N'(1);
                dir_next     = DIR_DOWN;
            end
        end
    end

    always_comb begin
        pwm_next = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pwm_next[c] = enable_eff[c] && (counter < duty_eff[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter       <= '0;
            dir           <= DIR_UP;
            mode          <= PWM_EDGE;
            shadow_duty   <= '0;
            shadow_enable <= '0;
            pwm_out       <= '0;
            period_start  <= 1'b0;
        end else begin
            period_start <= load;
            if (tick) begin
                counter <= counter_next;
                dir     <= dir_next;
                pwm_out <= pwm_next;
                if (load) begin
                    mode          <= mode_eff;
                    shadow_duty   <= duty;
                    shadow_enable <= enable;
                end
            end
        end
    end

endmodule

// File: doc/pwm_multichannel.md
PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

Interface
REQ-001 The block SHALL have parameter N, default 10: duty and counter resolution in bits, minimum 2.
REQ-002 The block SHALL have parameter CLK_DIV, default 3: prescaler width; one tick every 2^CLK_DIV clk cycles, minimum 1.
REQ-003 The block SHALL have parameter CHANNELS, default 2: number of independent PWM outputs, minimum 1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port duty, input, CHANNELS x N bits (packed array): requested duty per channel.
REQ-007 The block SHALL have port enable, input, CHANNELS bits: per-channel output enable.
REQ-008 The block SHALL have port center_mode, input, 1 bit: 0 = edge-aligned, 1 = center-aligned.
REQ-009 The block SHALL have port pwm_out, output, CHANNELS bits: registered PWM outputs.
REQ-010 The block SHALL have port period_start, output, 1 bit: one-clk pulse marking each shadow load.

Function
REQ-011 The prescaler SHALL count on every clk and assert tick for one clk when it equals 2^CLK_DIV-1, then wrap to 0; no derived clocks.
REQ-012 The period counter (N bits) and the outputs SHALL change only on clk cycles where tick=1.
REQ-013 In edge mode the counter SHALL count 0,1,...,2^N-1 and then wrap to 0; period = 2^N ticks.
REQ-014 In center mode the counter SHALL count up from 0 to M=2^N-1, reverse at M, and count down to 0, reversing again at 0; period = 2M ticks.
REQ-015 The load event SHALL be tick AND counter==0, with the counter value taken before the update.
REQ-016 On the load event the block SHALL latch duty, enable and center_mode into shadow registers; inputs SHALL be ignored at all other times.
REQ-017 On the load event the direction SHALL be set to up, whichever mode is latched.
REQ-018 On every tick, pwm_out[c] SHALL be set to shadow enable[c] AND (current counter < shadow duty[c]); on a load tick the newly latched shadow values SHALL be used.
REQ-019 In edge mode, pwm_out SHALL be high for exactly duty ticks per period.
REQ-020 In center mode, pwm_out SHALL be high for exactly 2*duty-1 ticks per period (0 when duty=0), centred on counter==0.
REQ-021 duty=0 SHALL hold the output low for the whole period.
REQ-022 duty=2^N-1 in edge mode SHALL give 2^N-1 high ticks out of 2^N; 100% duty is not supported.
REQ-023 period_start SHALL be 1 for exactly the clk cycle in which the load occurs and 0 otherwise.
REQ-024 Input changes within a period, including mode changes, SHALL take effect only at the next load event.
REQ-025 Channels SHALL share the counter and the load event, so all outputs are phase-aligned.

Reset
REQ-026 While reset=1 at a clk edge, the prescaler SHALL go to 0, the counter to 0, direction to up, shadow duty to 0, shadow enable to 0, mode to edge, pwm_out to 0 and period_start to 0.
REQ-027 A reset mid-period SHALL abort that period; pwm_out SHALL be 0 from the next clk edge, and the first load SHALL occur on the first tick after reset deasserts (2^CLK_DIV clk later).

Structure
REQ-028 Package pwm_pkg SHALL hold the enum pwm_mode_t (PWM_EDGE, PWM_CENTER), the enum pwm_dir_t (DIR_UP, DIR_DOWN) and the default parameter constants.
REQ-029 The prescaler SHALL be a separate sub-module, pwm_prescaler (parameter CLK_DIV; ports clk, reset, tick); the remaining logic SHALL be in pwm_multichannel.

Verification (N=4, CLK_DIV=1, CHANNELS=2 unless stated)
REQ-030 Edge, duty0=5, enable=2'b11 -> pwm_out[0] high 10 clk in every 32-clk period; period_start pulses every 32 clk.
REQ-031 Center, duty0=5 -> pwm_out[0] high 18 clk per 60-clk period, with the high window symmetric about counter==0.
REQ-032 Duty changed 5->12 mid-period -> the current period still gives 10 clk high; the next gives 24 clk high, starting at the period_start pulse.
REQ-033 duty0=0 and duty1=15, edge -> pwm_out[0] always 0; pwm_out[1] low for exactly 2 clk per 32.
REQ-034 enable=2'b01 with duty1=8 -> pwm_out[1] stays 0; disabling mid-period takes effect only at the next load.
REQ-035 reset asserted mid-pulse -> pwm_out=0 and period_start=0 on the next edge; after release, the first period_start comes 2 clk later.
